// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: host byte-stream packet engine. RX turns [addr][len][payload] packets into
// one-hot write strobes; TX frames the lowest-indexed pending target message as [addr][len][data].
module cmd_dispatcher #(
    parameter int unsigned N       = 28,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   master_data,
    output logic [N-1:0] valid_bus,
    input  logic [N-1:0] have_msg_bus,
    input  logic [7:0]   len,
    input  logic [7:0]   slave_data,
    output logic [N-1:0] rdreq_bus,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         err_addr,
    output logic         err_timeout
);
    localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
    localparam int unsigned   IW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]    NADDR  = 9'(N);
    localparam logic [N-1:0]  ONE    = N'(1);

    typedef enum logic [1:0] {R_ADDR, R_LEN, R_DATA} rx_state_e;
    typedef enum logic [2:0] {T_IDLE, T_ADDR, T_LEN, T_LOAD, T_DATA} tx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [7:0]    addr_q, addr_d;
    logic          addr_ok_q, addr_ok_d;
    logic [7:0]    rx_cnt_q, rx_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    master_data_q, master_data_d;
    logic [N-1:0]  valid_bus_q, valid_bus_d;
    logic          err_addr_q, err_addr_d;
    logic          err_timeout_q, err_timeout_d;

    tx_state_e     tx_state_q, tx_state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [7:0]    tx_len_q, tx_len_d;
    logic [7:0]    left_q, left_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [N-1:0]  rdreq_q, rdreq_d;

    logic [IW-1:0] pick;
    logic          pick_vld;

    always_comb begin
        rx_state_d    = rx_state_q;
        addr_d        = addr_q;
        addr_ok_d     = addr_ok_q;
        rx_cnt_d      = rx_cnt_q;
        tmr_d         = '0;
        master_data_d = master_data_q;
        valid_bus_d   = '0;
        err_addr_d    = 1'b0;
        err_timeout_d = 1'b0;

        // Idle timer runs only inside a packet; any byte restarts it.
        if (rx_state_q != R_ADDR && !rx_valid) begin
            if (tmr_q == T_LAST) begin
                rx_state_d    = R_ADDR;
                err_timeout_d = 1'b1;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end

        if (rx_valid) begin
            case (rx_state_q)
                R_ADDR: begin
                    addr_d     = rx_data;
                    addr_ok_d  = ({1'b0, rx_data} < NADDR);
                    err_addr_d = !({1'b0, rx_data} < NADDR);
                    rx_state_d = R_LEN;
                end
                R_LEN: begin
                    rx_cnt_d   = rx_data;
                    rx_state_d = (rx_data == 8'd0) ? R_ADDR : R_DATA;
                end
                R_DATA: begin
                    if (addr_ok_q) begin
                        master_data_d = rx_data;
                        valid_bus_d   = ONE << addr_q;
                    end
                    rx_cnt_d = rx_cnt_q - 8'd1;
                    if (rx_cnt_q == 8'd1) rx_state_d = R_ADDR;
                end
                default: rx_state_d = R_ADDR;
            endcase
        end
    end

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (have_msg_bus[i] && !pick_vld) begin
                pick     = IW'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        sel_d      = sel_q;
        tx_len_d   = tx_len_q;
        left_d     = left_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rdreq_d    = '0;

        case (tx_state_q)
            T_IDLE: begin
                // Hold off while a zero-length drop pulse is out so the stale have bit is not re-picked.
                if (pick_vld && rdreq_q == '0) begin
                    sel_d      = pick;
                    tx_len_d   = len;
                    tx_data_d  = 8'(pick);
                    tx_valid_d = 1'b1;
                    tx_state_d = T_ADDR;
                end
            end
            T_ADDR: begin
                if (tx_ready) begin
                    tx_data_d  = tx_len_q;
                    tx_state_d = T_LEN;
                end
            end
            T_LEN: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    rdreq_d    = ONE << sel_q;
                    left_d     = tx_len_q;
                    tx_state_d = (tx_len_q == 8'd0) ? T_IDLE : T_LOAD;
                end
            end
            T_LOAD: begin
                tx_data_d  = slave_data;
                tx_valid_d = 1'b1;
                left_d     = left_q - 8'd1;
                tx_state_d = T_DATA;
            end
            T_DATA: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (left_q != 8'd0) begin
                        rdreq_d    = ONE << sel_q;
                        tx_state_d = T_LOAD;
                    end else begin
                        tx_state_d = T_IDLE;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_state_q    <= R_ADDR;
            addr_q        <= '0;
            addr_ok_q     <= 1'b0;
            rx_cnt_q      <= '0;
            tmr_q         <= '0;
            master_data_q <= '0;
            valid_bus_q   <= '0;
            err_addr_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            tx_state_q    <= T_IDLE;
            sel_q         <= '0;
            tx_len_q      <= '0;
            left_q        <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            rdreq_q       <= '0;
        end else begin
            rx_state_q    <= rx_state_d;
            addr_q        <= addr_d;
            addr_ok_q     <= addr_ok_d;
            rx_cnt_q      <= rx_cnt_d;
            tmr_q         <= tmr_d;
            master_data_q <= master_data_d;
            valid_bus_q   <= valid_bus_d;
            err_addr_q    <= err_addr_d;
            err_timeout_q <= err_timeout_d;
            tx_state_q    <= tx_state_d;
            sel_q         <= sel_d;
            tx_len_q      <= tx_len_d;
            left_q        <= left_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            rdreq_q       <= rdreq_d;
        end
    end

    assign master_data = master_data_q;
    assign valid_bus   = valid_bus_q;
    assign err_addr    = err_addr_q;
    assign err_timeout = err_timeout_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign rdreq_bus   = rdreq_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: randomized bench; RX packets are predicted per cycle by a packet-level model,
// TX output is compared against the expected [addr][len][data] byte stream of emulated targets.
`timescale 1ns/1ps
module tb_cmd_dispatcher;
    localparam int N       = 28;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [7:0]   master_data;
    logic [N-1:0] valid_bus;
    logic [N-1:0] have_msg_bus = '0;
    logic [7:0]   len = '0;
    logic [7:0]   slave_data = '0;
    logic [N-1:0] rdreq_bus;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         err_addr;
    logic         err_timeout;

    cmd_dispatcher #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .master_data(master_data), .valid_bus(valid_bus), .have_msg_bus(have_msg_bus),
        .len(len), .slave_data(slave_data), .rdreq_bus(rdreq_bus), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .err_addr(err_addr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

    // RX reference: packet position plus per-cycle expected events keyed by cycle number.
    int pos = 0, p_addr = 0, p_len = 0, last_p = 0;
    logic [N-1:0] exp_vb [int];
    logic [7:0]   exp_md [int];
    bit           exp_ea [int];
    bit           exp_et [int];
    logic [7:0]   md_hold = '0;

    function automatic void rx_model(input int b, input int gap, input int p);
        if (pos > 0 && gap >= TIMEOUT) begin
            exp_et[last_p + TIMEOUT] = 1'b1;
            pos = 0;
        end
        if (pos == 0) begin
            p_addr = b;
            if (b >= N) exp_ea[p] = 1'b1;
            pos = 1;
        end else if (pos == 1) begin
            p_len = b;
            pos = (b == 0) ? 0 : 2;
        end else begin
            if (p_addr < N) begin
                exp_vb[p] = onehot(p_addr);
                exp_md[p] = 8'(b);
            end
            pos = (pos - 1 == p_len) ? 0 : pos + 1;
        end
        last_p = p;
    endfunction

    task automatic rx_byte(input int b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_model(b, gap, cyc + 1);
        rx_data  = 8'(b);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rx_quiet();
        if (pos > 0) begin
            exp_et[last_p + TIMEOUT] = 1'b1;
            pos = 0;
        end
        repeat (TIMEOUT + 4) tick();
    endtask

    // Emulated targets: one message each, popped one byte per rdreq; lowest pending target is muxed.
    bit           thave [N];
    logic [7:0]   tlen [N];
    logic [7:0]   tq [N][$];
    logic [7:0]   exp_tx [$];
    int           rd_cnt [N];
    logic [N-1:0] pend_rd = '0;
    int           ready_pct = 70;
    int           hs_cnt = 0;
    bit           prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0]   prev_data = '0;
    logic [N-1:0] evb;

    task automatic drive_tgt();
        have_msg_bus = '0;
        len          = '0;
        slave_data   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (thave[i]) begin
                have_msg_bus[i] = 1'b1;
                len        = tlen[i];
                slave_data = (tq[i].size() > 0) ? tq[i][0] : 8'h00;
            end
        end
    endtask

    initial begin
        forever begin
            tick();
            if (n_rst) begin
                for (int i = 0; i < N; i++) begin
                    if (pend_rd[i]) begin
                        if (tq[i].size() > 0) void'(tq[i].pop_front());
                        if (tq[i].size() == 0) thave[i] = 1'b0;
                    end
                end
            end
            pend_rd  = '0;
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            drive_tgt();
        end
    end

    always @(negedge clk) begin
        if (!n_rst) begin
            check("rst_valid_bus", 32'(valid_bus), 32'h0);
            check("rst_master_data", 32'(master_data), 32'h0);
            check("rst_rdreq_bus", 32'(rdreq_bus), 32'h0);
            check("rst_tx_data", 32'(tx_data), 32'h0);
            check("rst_tx_valid", 32'(tx_valid), 32'h0);
            check("rst_err_addr", 32'(err_addr), 32'h0);
            check("rst_err_timeout", 32'(err_timeout), 32'h0);
            prev_valid = 1'b0;
        end else begin
            evb = exp_vb.exists(cyc) ? exp_vb[cyc] : '0;
            if (exp_md.exists(cyc)) md_hold = exp_md[cyc];
            check("valid_bus", 32'(valid_bus), 32'(evb));
            check("master_data", 32'(master_data), 32'(md_hold));
            check("err_addr", 32'(err_addr), 32'(exp_ea.exists(cyc)));
            check("err_timeout", 32'(err_timeout), 32'(exp_et.exists(cyc)));
            exp_vb.delete(cyc);
            exp_md.delete(cyc);
            exp_ea.delete(cyc);
            exp_et.delete(cyc);

            if (prev_valid && !prev_ready) begin
                check("tx_hold_valid", 32'(tx_valid), 32'h1);
                check("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                if (exp_tx.size() > 0) check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                else check("tx_spurious", 32'(tx_valid), 32'h0);
            end else if (exp_tx.size() == 0) begin
                check("tx_idle", 32'(tx_valid), 32'h0);
            end
            if (rdreq_bus != '0) begin
                check("rdreq_onehot", 32'($countones(rdreq_bus)), 32'h1);
                check("rdreq_target", 32'(rdreq_bus & have_msg_bus), 32'(rdreq_bus));
                for (int i = 0; i < N; i++) if (rdreq_bus[i]) rd_cnt[i]++;
            end
            pend_rd    = rdreq_bus;
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic load_msg(input int i, input int l, input int d);
        thave[i] = 1'b1;
        tlen[i]  = 8'(l);
        tq[i].delete();
        for (int k = 0; k < l; k++) tq[i].push_back((d < 0) ? 8'($urandom_range(0, 255)) : 8'(d));
        exp_tx.push_back(8'(i));
        exp_tx.push_back(8'(l));
        foreach (tq[i][k]) exp_tx.push_back(tq[i][k]);
    endtask

    task automatic tx_batch(input logic [N-1:0] set, input int fl, input int fd);
        int n = 0;
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
        for (int i = 0; i < N; i++)
            if (set[i]) load_msg(i, (fl < 0) ? $urandom_range(0, 5) : fl, fd);
        drive_tgt();
        while (exp_tx.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check("tx_drain", 32'(exp_tx.size()), 32'h0);
        check("have_drained", 32'(have_msg_bus), 32'h0);
        for (int i = 0; i < N; i++)
            check("rdreq_count", 32'(rd_cnt[i]), set[i] ? 32'((tlen[i] == 0) ? 1 : tlen[i]) : 32'h0);
    endtask

    task automatic clear_models();
        pos = 0;
        exp_vb.delete();
        exp_md.delete();
        exp_ea.delete();
        exp_et.delete();
        md_hold = '0;
        exp_tx.delete();
        for (int i = 0; i < N; i++) begin
            thave[i] = 1'b0;
            tq[i].delete();
        end
        pend_rd  = '0;
        rx_valid = 1'b0;
        drive_tgt();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int dir [$];
        logic [N-1:0] s;
        int n;
        #2 n_rst = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        dir = {5, 1, 'h3C, 'h0B, 3, 'h11, 'h22, 'h33, 'h40, 1, 'hFF, 5, 1, 1,
               27, 1, 'h5A, 28, 1, 'h5B, 4, 0, 6, 2, 'h61, 'h62};
        foreach (dir[k]) rx_byte(dir[k], $urandom_range(0, 2));

        rx_byte(5, 0); rx_byte(2, 0); rx_byte('hAA, 0);
        rx_quiet();
        rx_byte(5, 0); rx_byte(1, 0); rx_byte(1, 0);
        rx_byte(7, 0); rx_byte(2, 0); rx_byte('h10, TIMEOUT - 1); rx_byte('h20, TIMEOUT - 1);
        rx_byte(9, 0); rx_byte(2, TIMEOUT); rx_byte(1, 0); rx_byte('h77, 0);
        repeat (3) tick();

        ready_pct = 50;
        s = '0; s[3] = 1'b1; s[24] = 1'b1;
        tx_batch(s, 1, 7);

        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    int a, l, r, g;
                    a = $urandom_range(0, 33);
                    l = $urandom_range(0, 4);
                    for (int k = 0; k < l + 2; k++) begin
                        r = $urandom_range(0, 29);
                        g = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 2);
                        rx_byte((k == 0) ? a : (k == 1) ? l : $urandom_range(0, 255), g);
                    end
                end
                rx_quiet();
            end
            begin
                for (int b = 0; b < 8; b++) begin
                    s = '0;
                    repeat ($urandom_range(1, 4)) s[$urandom_range(0, N - 1)] = 1'b1;
                    tx_batch(s, -1, -1);
                end
            end
        join

        // Reset while TX sits in a data beat and an RX packet is half received.
        ready_pct = 100;
        load_msg(2, 6, -1);
        drive_tgt();
        n = hs_cnt;
        rx_byte(5, 0); rx_byte(3, 0); rx_byte('h11, 0);
        for (int k = 0; k < 200 && hs_cnt < n + 4; k++) tick();
        check("rst_setup_handshakes", 32'(hs_cnt - n >= 4), 32'h1);
        tick();
        #2 n_rst = 1'b0;
        clear_models();
        repeat (3) tick();
        n_rst = 1'b1;
        repeat (20) tick();
        rx_byte(5, 0); rx_byte(1, 0); rx_byte(1, 0);
        ready_pct = 60;
        s = '0; s[9] = 1'b1;
        tx_batch(s, 3, -1);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
